// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: address/count width helpers
// and the registered status-flag bundle.
package fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one read port with a registered
// output that holds its value when no read is performed.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Array kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data, registered status flags,
// write-acknowledge / read-valid strobes and occupancy counts.
module async_fifo
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 8,
    parameter  int ALMOST_WR  = 2,
    parameter  int ALMOST_RD  = 1,
    localparam int AW         = clog2(FIFO_DEPTH),
    localparam int CW         = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  valid,
    output logic [CW-1:0]         wr_count,
    output logic [CW-1:0]         rd_count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(FIFO_DEPTH - ALMOST_WR);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_RD);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    fifo_flags_t   flags_q, flags_d;
    logic          wr_ack_q, wr_ack_d;
    logic          valid_q, valid_d;
    logic          wr_accept;
    logic          rd_accept;

    // Acceptance uses the registered flags, i.e. the state before this edge.
    always_comb begin
        wr_accept = wr_en && !flags_q.full;
        rd_accept = rd_en && !flags_q.empty;

        wr_ptr_d = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_accept ? rd_ptr_q + AW'(1) : rd_ptr_q;

        occ_d = occ_q;
        case ({wr_accept, rd_accept})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        flags_d.full         = (occ_d == DEPTH_C);
        flags_d.empty        = (occ_d == '0);
        flags_d.almost_full  = (occ_d >= AF_C);
        flags_d.almost_empty = (occ_d <= AE_C);

        wr_ack_d = wr_accept;
        valid_d  = rd_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            flags_q  <= FLAGS_RESET;
            wr_ack_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            flags_q  <= flags_d;
            wr_ack_q <= wr_ack_d;
            valid_q  <= valid_d;
        end
    end

    // Reads and writes never target the same slot in one cycle: empty blocks
    // the read, full blocks the write.
    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (dout)
    );

    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign wr_ack       = wr_ack_q;
    assign valid        = valid_q;
    assign wr_count     = occ_q;
    assign rd_count     = occ_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo (8x8): stimulus pushes hand-computed expected
// responses into a scoreboard queue; a monitor pops and compares them.
module tb_async_fifo;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, valid;
    logic [CW-1:0] wr_count, rd_count;

    async_fifo #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8),
        .ALMOST_WR  (2),
        .ALMOST_RD  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .valid        (valid),
        .wr_count     (wr_count),
        .rd_count     (rd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            issue_cyc;
        int            id;
        bit            exp_ack;
        bit            exp_valid;
        logic [DW-1:0] exp_dout;
        logic [CW-1:0] exp_cnt;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_miss = 0;
    int            vec_id = 0;
    logic [DW-1:0] hold_dout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Compares every output against one expected response; flags follow from
    // the expected occupancy (full==8, empty==0, almost_full>=6, almost_empty<=1).
    task automatic check_outputs(input string tag, input int id, input bit eack,
                                 input bit evalid, input logic [DW-1:0] edout,
                                 input logic [CW-1:0] ecnt);
        logic [3:0] eflags;
        logic [3:0] gflags;
        bit         bad;
        bad    = 1'b0;
        eflags = {ecnt == 4'd8, ecnt == 4'd0, ecnt >= 4'd6, ecnt <= 4'd1};
        gflags = {full, empty, almost_full, almost_empty};
        if (wr_ack !== eack) begin
            $display("FAIL %s#%0d wr_ack got %b want %b", tag, id, wr_ack, eack);
            bad = 1'b1;
        end
        if (valid !== evalid) begin
            $display("FAIL %s#%0d valid got %b want %b", tag, id, valid, evalid);
            bad = 1'b1;
        end
        if (dout !== edout) begin
            $display("FAIL %s#%0d dout got %h want %h", tag, id, dout, edout);
            bad = 1'b1;
        end
        if (wr_count !== ecnt || rd_count !== ecnt) begin
            $display("FAIL %s#%0d count got wr=%0d rd=%0d want %0d", tag, id, wr_count, rd_count, ecnt);
            bad = 1'b1;
        end
        if (gflags !== eflags) begin
            $display("FAIL %s#%0d flags{full,empty,af,ae} got %b want %b", tag, id, gflags, eflags);
            bad = 1'b1;
        end
        n_vec = n_vec + 1;
        if (bad) n_miss = n_miss + 1;
        $display("vec %s#%0d wr_ack=%b valid=%b dout=%h cnt=%0d %s", tag, id, wr_ack, valid, dout, wr_count, bad ? "bad" : "ok");
    endtask

    task automatic issue(input bit wr, input logic [DW-1:0] d, input bit rd,
                         input bit eack, input bit evalid, input logic [DW-1:0] edata,
                         input logic [CW-1:0] ecnt);
        exp_t e;
        @(negedge clk);
        wr_en = wr;
        din   = d;
        rd_en = rd;
        if (evalid) hold_dout = edata;
        e.issue_cyc = cyc;
        e.id        = vec_id;
        e.exp_ack   = eack;
        e.exp_valid = evalid;
        e.exp_dout  = hold_dout;
        e.exp_cnt   = ecnt;
        vec_id      = vec_id + 1;
        sb_q.push_back(e);
    endtask

    // Monitor: a record becomes due one clock after it was issued.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].issue_cyc < cyc) begin
                mon_e = sb_q.pop_front();
                check_outputs("sb", mon_e.id, mon_e.exp_ack, mon_e.exp_valid, mon_e.exp_dout, mon_e.exp_cnt);
            end else if (rst_n === 1'b1 && (valid === 1'b1 || wr_ack === 1'b1)) begin
                n_vec  = n_vec + 1;
                n_miss = n_miss + 1;
                $display("FAIL unexpected_strobe got wr_ack=%b valid=%b want 0 0", wr_ack, valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] under_tbl [8];
    int            wait_cnt;

    initial begin
        under_tbl = '{8'd17, 8'd20, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};

        // Reset held for 20 clocks.
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 0, 1'b0, 1'b0, 8'h00, 4'd0);
        rst_n = 1'b1;
        issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);

        // Overflow: 10 writes, last two dropped.
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, (i == 0) ? 8'd17 : (i == 1) ? 8'd20 : 8'(800 + i - 2), 1'b0,
                  (i < 8), 1'b0, 8'h00, 4'((i < 8) ? i + 1 : 8));
        end
        issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd8);

        // Underflow: 14 reads, last six rejected with dout held at 0x25.
        for (int i = 0; i < 14; i++) begin
            issue(1'b0, 8'h00, 1'b1, 1'b0, (i < 8), (i < 8) ? under_tbl[i] : 8'h00,
                  4'((i < 8) ? 7 - i : 0));
        end

        // Offset the pointers by 3 so the next 8 entries straddle the wrap.
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1, 1'b0, 8'h00, 4'(i + 1));
        end
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), 4'(2 - i));
        end

        // Wrap-around: write 1..10, read 14.
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, 8'(i + 1), 1'b0, (i < 8), 1'b0, 8'h00, 4'((i < 8) ? i + 1 : 8));
        end
        for (int i = 0; i < 14; i++) begin
            issue(1'b0, 8'h00, 1'b1, 1'b0, (i < 8), 8'((i < 8) ? i + 1 : 0),
                  4'((i < 8) ? 7 - i : 0));
        end

        // Simultaneous read+write at occupancy 4.
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0, 8'h00, 4'(i + 1));
        end
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, 8'(8'h50 + i), 1'b1, 1'b1, 1'b1,
                  (i < 4) ? 8'(8'h40 + i) : 8'(8'h50 + i - 4), 4'd4);
        end

        // Mid-operation reset at occupancy 5.
        issue(1'b1, 8'h60, 1'b0, 1'b1, 1'b0, 8'h00, 4'd5);
        issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd5);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs("midreset", 0, 1'b0, 1'b0, 8'h00, 4'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        hold_dout = 8'h00;
        issue(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
        issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt = wait_cnt + 1;
        end
        n_vec = n_vec + 1;
        if (sb_q.size() != 0) begin
            n_miss = n_miss + 1;
            $display("FAIL drain pending got %0d want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Parameterised FIFO buffer between a producer and a consumer, with first-word-fall-through disabled: read data is registered.
- Provides full/empty and programmable almost-full/almost-empty flags, write-acknowledge and read-valid strobes, and occupancy counts.
- One clock; reset is asynchronous and active-low.
- Production configuration is DATA_WIDTH=16, FIFO_DEPTH=64; the verification default is 8x8.

Parameters:
- DATA_WIDTH, 8, width of din/dout in bits.
- FIFO_DEPTH, 8, number of entries; must be a power of two, at least 4.
- ALMOST_WR, 2, almost_full asserts when occupancy >= FIFO_DEPTH-ALMOST_WR.
- ALMOST_RD, 1, almost_empty asserts when occupancy <= ALMOST_RD.
- Derived constant AW = clog2(FIFO_DEPTH), the address width. The count width is AW+1 (4 bits for depth 8).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  registered read data.
- full  out  1  occupancy == FIFO_DEPTH.
- empty  out  1  occupancy == 0.
- almost_full  out  1  see ALMOST_WR.
- almost_empty  out  1  see ALMOST_RD.
- wr_ack  out  1  previous-cycle write was accepted.
- valid  out  1  dout carries data from an accepted read.
- wr_count  out  AW+1  occupancy seen by the writer.
- rd_count  out  AW+1  occupancy seen by the reader.

Behaviour:
- Reset (asynchronous, with rst_n low) puts every output and all internal state in this condition:
  - wr/rd pointers = 0 and occupancy = 0.
  - dout = 0, wr_ack = 0, valid = 0.
  - full = 0, almost_full = 0.
  - empty = 1, almost_empty = 1.
  - wr_count = 0, rd_count = 0.
- Reset mid-operation discards all stored data. Memory contents need not be cleared.
- Write acceptance: accepted = wr_en && !full, using the flag value before the clock edge.
  - An accepted write stores din at wr_ptr and increments wr_ptr, modulo FIFO_DEPTH.
  - wr_ack is high in the cycle after an accepted write and low otherwise.
  - A write while full is dropped silently: no state change, wr_ack = 0.
- Read acceptance: accepted = rd_en && !empty.
  - On the clock edge, mem[rd_ptr] is loaded into dout, rd_ptr increments modulo FIFO_DEPTH, and valid = 1 in the next cycle. Latency is 1 cycle.
  - A read while empty has no effect: valid = 0 and dout holds its last value.
- Simultaneous accepted read and write: both pointers advance and occupancy is unchanged.
  - When empty, only the write is accepted.
  - When full, only the read is accepted; the write is dropped.
- Occupancy is an (AW+1)-bit register: +1 on write-only, -1 on read-only.
- All flags and counts are registered and reflect occupancy after the edge:
  - full = (occ == FIFO_DEPTH)
  - empty = (occ == 0)
  - almost_full = (occ >= FIFO_DEPTH-ALMOST_WR)
  - almost_empty = (occ <= ALMOST_RD)
- wr_count = rd_count = occ.
- Pointers wrap from FIFO_DEPTH-1 to 0 with no gap. Ordering is strictly FIFO across wrap.
- din wider values are the caller's concern. Only DATA_WIDTH bits are stored.

Decomposition:
- Shared package fifo_pkg: clog2 function and a count-width helper.
- One sub-module, fifo_ram: simple dual-port memory, DATA_WIDTH x FIFO_DEPTH, one write port, registered read port.
- async_fifo holds pointers, occupancy, flags and handshakes.

Test Plan:
- Reset: hold rst_n low for 20 clocks, then release.
  - Response: empty=1, almost_empty=1, full=0, counts=0, dout=0, wr_ack=0, valid=0.
- Overflow: write 10 single-cycle words 17,20,0x20..0x27 (8-bit truncation of 800..807).
  - Response: first 8 get wr_ack=1.
  - almost_full rises at count 6; full rises at count 8.
  - Words 9 and 10 get wr_ack=0; count stays 8.
- Underflow: issue 14 single-cycle reads.
  - Response: dout = 17,20,0x20..0x25 with valid=1, so 8 valids.
  - almost_empty rises at count 1; empty rises after the 8th read.
  - Reads 9-14 give valid=0 with dout holding 0x25.
- Wrap-around: write 1..10, then read 14.
  - Response: 1..8 accepted and read back in order across the pointer wrap.
  - Extra writes and reads are rejected as above.
- Simultaneous: with occupancy 4, assert wr_en and rd_en together for 10 cycles.
  - Response: count stays 4 and every wr_ack=1 and valid=1.
  - Data order is preserved.
- Mid-operation reset: pulse rst_n low with occupancy 5.
  - Response: immediately empty=1, counts=0.
  - The next read is rejected.
